// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, state type and lane index helper for the FFT twiddle sequencer
package fft_pkg;
  localparam int N_POINT = 512;
  localparam int LANES   = 16;
  localparam int IDX_W   = $clog2(N_POINT);
  localparam int TWF_W   = 9;
  localparam int BEATS   = N_POINT / LANES;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FCNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } twf_seq_state_e;

  // ROM index for one lane of one beat: beat * LANES + lane, never above N_POINT-1
  function automatic logic [IDX_W-1:0] twf_lane_idx(input logic [BEAT_W-1:0] beat, input int lane);
    return IDX_W'(beat) * IDX_W'(LANES) + IDX_W'(lane);
  endfunction
endpackage

// File: rtl/fft_valid_pipe.sv
// rtl/fft_valid_pipe.sv - valid/last delay line matching the twiddle multiplier latency
module fft_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic adv_i,
  input  logic valid_i,
  input  logic last_i,
  output logic valid_o,
  output logic last_o
);
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] l_q;

  // Whole line moves together on adv so bubbles keep their slots
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q <= '0;
      l_q <= '0;
    end else if (adv_i) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        v_q[i] <= v_q[i-1];
        l_q[i] <= l_q[i-1];
      end
      v_q[0] <= valid_i;
      l_q[0] <= last_i;
    end
  end

  assign valid_o = v_q[DEPTH-1];
  assign last_o  = l_q[DEPTH-1];
endmodule

// File: rtl/fft_twf_seq.sv
// rtl/fft_twf_seq.sv - twiddle index sequencer and frame stream controller for one FFT stage
module fft_twf_seq
  import fft_pkg::*;
#(
  parameter int DATA_LAT = 2,
  parameter int NFR_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NFR_W-1:0]         num_frames,
  input  logic                     abort,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [LANES*IDX_W-1:0]   twf_idx,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     dout_last,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     done
);
  twf_seq_state_e    state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [NFR_W-1:0]  frames_left_q, frames_left_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic clr;
  logic adv;
  logic accept;
  logic last_beat;

  assign clr        = rst | abort;
  assign adv        = ~dout_valid | dout_ready;
  assign last_beat  = (beat_cnt_q == BEAT_W'(BEATS - 1));
  assign frame_done = dout_valid & dout_ready & dout_last;

  fft_valid_pipe #(
    .DEPTH(DATA_LAT)
  ) u_pipe (
    .clk_i  (clk),
    .rst_i  (clr),
    .adv_i  (adv),
    .valid_i(accept),
    .last_i (accept & last_beat),
    .valid_o(dout_valid),
    .last_o (dout_last)
  );

  // Indices are only driven while frames are being accepted; the ROMs see 0 otherwise
  always_comb begin
    twf_idx = '0;
    if (state_q == RUN) begin
      for (int l = 0; l < LANES; l++) begin
        twf_idx[l*IDX_W +: IDX_W] = twf_lane_idx(beat_cnt_q, l);
      end
    end
  end

  // Next state, beat/frame counters and handshake outputs
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    frames_left_d = frames_left_q;
    frame_cnt_d   = frame_cnt_q;
    din_ready     = 1'b0;
    accept        = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          frames_left_d = (num_frames == '0) ? NFR_W'(1) : num_frames;
          state_d       = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        din_ready = adv;
        accept    = din_valid & adv;
        if (accept) begin
          beat_cnt_d = last_beat ? '0 : beat_cnt_q + BEAT_W'(1);
          if (last_beat) begin
            frames_left_d = frames_left_q - NFR_W'(1);
            if (frames_left_q == NFR_W'(1)) begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        // Pipeline is shorter than a frame, so the only last beat left is the final one
        busy = 1'b1;
        if (frame_done) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers; abort clears exactly like reset
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      frames_left_q <= '0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      frames_left_q <= frames_left_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end
endmodule

// File: tb/tb_fft_twf_seq.sv
// tb/tb_fft_twf_seq.sv - self-checking bench for fft_twf_seq
module tb_fft_twf_seq;
  import fft_pkg::*;

  localparam int DATA_LAT = 2;
  localparam int NFR_W    = 8;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic [NFR_W-1:0]       num_frames;
  logic                   abort;
  logic                   din_valid;
  logic                   din_ready;
  logic [LANES*IDX_W-1:0] twf_idx;
  logic                   dout_valid;
  logic                   dout_ready;
  logic                   dout_last;
  logic                   frame_done;
  logic                   busy;
  logic                   done;

  fft_twf_seq #(
    .DATA_LAT(DATA_LAT),
    .NFR_W   (NFR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_frames(num_frames),
    .abort     (abort),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .twf_idx   (twf_idx),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_last (dout_last),
    .frame_done(frame_done),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       last;
    int       cyc;
    int       stalls;
  } sb_t;

  typedef struct {
    bit       start;
    bit [7:0] nf;
    bit       abort;
    bit       dv;
    bit       dr;
    bit       e_rdy;
    bit       e_ov;
    bit       e_ol;
    bit       e_fd;
    bit       e_busy;
    bit       e_done;
    int       e_idx0;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mdl_beat = 0;
  int   stalls = 0;
  int   acc_cnt = 0;
  int   out_beats = 0;
  int   fd_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   fd_since_clr = 0;
  sb_t  sbq[$];
  int   lacc[$];
  int   fd_cyc[$];
  int   last_pos[$];
  vec_t tbl[10];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lane_idx(input int lane);
    return int'(twf_idx[lane*IDX_W +: IDX_W]);
  endfunction

  // Scoreboard update for the current cycle, called after inputs have settled
  task automatic sample();
    sb_t e;
    int  bad;
    bit  exp_fd;
    if (rst || abort) begin
      sbq.delete();
      mdl_beat     = 0;
      fd_since_clr = 0;
      return;
    end
    exp_fd = 1'b0;
    if (dout_valid && !dout_ready) stalls++;
    if (din_valid && din_ready) begin
      bad = 0;
      for (int l = LANES - 1; l >= 0; l--) begin
        if (lane_idx(l) != mdl_beat * LANES + l) bad = l;
      end
      chk("idx_lane", lane_idx(bad), mdl_beat * LANES + bad);
      sbq.push_back('{last: (mdl_beat == BEATS - 1), cyc: cyc, stalls: stalls});
      if (mdl_beat == BEATS - 1) lacc.push_back(cyc);
      mdl_beat = (mdl_beat + 1) % BEATS;
      acc_cnt++;
    end
    if (dout_valid && dout_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_beat", 1, 0);
      end else begin
        e = sbq.pop_front();
        exp_fd = e.last;
        chk("dout_last", dout_last, e.last);
        if (e.stalls == stalls) chk("latency", cyc - e.cyc, DATA_LAT);
        out_beats++;
        if (dout_last) last_pos.push_back(out_beats);
      end
    end
    chk("frame_done", frame_done, exp_fd);
    if (frame_done) begin
      fd_cnt++;
      fd_since_clr++;
      fd_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_with_frame_done", frame_done, 1);
    end
  endtask

  task automatic settle();
    #1;
    sample();
  endtask

  task automatic adv_clk();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_cmd(input int nf, input int vpct, input int stall_at, input int stall_len,
                         input int restart_at, input string tag);
    int nfe = (nf == 0) ? 1 : nf;
    int fd0 = fd_cnt;
    int dn0 = done_cnt;
    int ob0 = out_beats;
    int lp0 = last_pos.size();
    int fc0 = fd_cyc.size();
    int la0 = lacc.size();
    int ac0 = acc_cnt;
    int st_done = 0;
    bit restarted = 1'b0;
    bit fin = 1'b0;
    start = 1'b1; num_frames = NFR_W'(nf); din_valid = 1'b0; dout_ready = 1'b1;
    settle(); adv_clk();
    start = 1'b0;
    settle();
    chk({tag, "_first_idx"}, lane_idx(0), 0);
    chk({tag, "_busy_run"}, busy, 1);
    adv_clk();
    for (int lim = 0; lim < 1000 && !fin; lim++) begin
      din_valid  = (vpct >= 100) ? 1'b1 : ($urandom_range(99) < vpct);
      dout_ready = 1'b1;
      start      = 1'b0;
      if (restart_at >= 0 && !restarted && acc_cnt - ac0 == restart_at) begin
        start = 1'b1; num_frames = 8'd5; restarted = 1'b1;
      end
      if (stall_at >= 0 && acc_cnt - ac0 >= stall_at && st_done < stall_len) begin
        dout_ready = 1'b0;
        st_done++;
      end
      settle();
      if (!dout_ready) begin
        chk({tag, "_stall_din_ready"}, din_ready, 0);
        chk({tag, "_stall_idx_hold"}, lane_idx(0), ((acc_cnt - ac0) % BEATS) * LANES);
      end
      if (done_cnt > dn0) fin = 1'b1;
      adv_clk();
    end
    start = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    chk({tag, "_finished"}, fin, 1);
    settle();
    chk({tag, "_busy_after_done"}, busy, 0);
    adv_clk();
    chk({tag, "_frame_dones"}, fd_cnt - fd0, nfe);
    chk({tag, "_dones"}, done_cnt - dn0, 1);
    chk({tag, "_out_beats"}, out_beats - ob0, BEATS * nfe);
    chk({tag, "_last_count"}, last_pos.size() - lp0, nfe);
    if (last_pos.size() - lp0 == nfe) begin
      for (int k = 0; k < nfe; k++) chk({tag, "_last_pos"}, last_pos[lp0+k] - ob0, BEATS * (k + 1));
    end
    if (fd_cyc.size() - fc0 == nfe && lacc.size() - la0 == nfe) begin
      chk({tag, "_done_cycle"}, done_cyc, fd_cyc[fc0+nfe-1]);
      if (vpct >= 100 && stall_len == 0) begin
        for (int k = 0; k < nfe; k++) begin
          chk({tag, "_fd_after_last_accept"}, fd_cyc[fc0+k] - lacc[la0+k], DATA_LAT);
          if (k > 0) chk({tag, "_fd_spacing"}, fd_cyc[fc0+k] - fd_cyc[fc0+k-1], BEATS);
        end
      end
    end
  endtask

  task automatic abort_run(input bit use_rst, input string tag);
    int ac0 = acc_cnt;
    int fd0 = fd_cnt;
    int dn0 = done_cnt;
    start = 1'b1; num_frames = 8'd1; din_valid = 1'b0; dout_ready = 1'b1;
    settle(); adv_clk();
    start = 1'b0;
    for (int lim = 0; lim < 100 && acc_cnt - ac0 < 10; lim++) begin
      din_valid = 1'b1;
      settle(); adv_clk();
    end
    chk({tag, "_reached_beat10"}, acc_cnt - ac0, 10);
    chk({tag, "_idx_at_beat10"}, lane_idx(0), 10 * LANES);
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    din_valid = 1'b1;
    settle(); adv_clk();
    rst = 1'b0; abort = 1'b0; din_valid = 1'b1;
    settle();
    chk({tag, "_din_ready"}, din_ready, 0);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_dout_last"}, dout_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_idx_zero"}, (twf_idx == '0), 1);
    adv_clk();
    din_valid = 1'b0;
    repeat (4) begin
      settle(); adv_clk();
    end
    chk({tag, "_no_frame_done"}, fd_cnt - fd0, 0);
    chk({tag, "_no_done"}, done_cnt - dn0, 0);
  endtask

  initial begin
    // start, nf, abort, dv, dr | rdy, ov, ol, fd, busy, done, idx0
    tbl[0] = '{0, 8'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 8'd0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 8'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 8'd0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0};
    tbl[4] = '{0, 8'd0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0};
    tbl[5] = '{1, 8'd5, 0, 1, 1, 1, 0, 0, 0, 1, 0, 16};
    tbl[6] = '{0, 8'd0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 32};
    tbl[7] = '{0, 8'd0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 32};
    tbl[8] = '{1, 8'd3, 1, 1, 0, 0, 1, 0, 0, 1, 0, 32};
    tbl[9] = '{0, 8'd0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1; start = 1'b0; num_frames = '0; abort = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    @(posedge clk); cyc++; #1;
    settle(); adv_clk();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      start = tbl[i].start; num_frames = tbl[i].nf; abort = tbl[i].abort;
      din_valid = tbl[i].dv; dout_ready = tbl[i].dr;
      settle();
      chk($sformatf("tbl%0d_din_ready", i), din_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_dout_valid", i), dout_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d_dout_last", i), dout_last, tbl[i].e_ol);
      chk($sformatf("tbl%0d_frame_done", i), frame_done, tbl[i].e_fd);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("tbl%0d_idx0", i), lane_idx(0), tbl[i].e_idx0);
      adv_clk();
    end
    start = 1'b0; abort = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;

    run_cmd(1, 100, -1, 0, -1, "single");
    run_cmd(3, 100, -1, 0, -1, "multi");
    chk("frame_cnt", 32'(dut.frame_cnt_q), fd_since_clr);
    run_cmd(1, 100, 12, 5, -1, "stall");
    abort_run(1'b0, "abort");
    run_cmd(1, 100, -1, 0, -1, "post_abort");
    run_cmd(0, 100, -1, 0, 5, "nf0_restart");
    abort_run(1'b1, "rst_mid");
    run_cmd(1, 100, -1, 0, -1, "post_rst");
    run_cmd(2, 50, -1, 0, -1, "bubbly");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
